// File: rtl/mdu_ctrl_if.sv
// Multiply/divide unit port bundle between the E stage and the MDU controller.
// Inputs carry the E-stage op and operands; outputs carry HI/LO, result and stall.
interface mdu_ctrl_if;
   logic        E_Valid;
   logic [3:0]  E_MDUOp;
   logic [31:0] E_RS;
   logic [31:0] E_RT;
   logic        D_UseMDU;
   logic        E_Start;
   logic        E_Busy;
   logic        E_MDUStall;
   logic [31:0] E_HI;
   logic [31:0] E_LO;
   logic [31:0] E_MDUResult;

   modport master (
      output E_Valid, E_MDUOp, E_RS, E_RT, D_UseMDU,
      input  E_Start, E_Busy, E_MDUStall, E_HI, E_LO, E_MDUResult
   );

   modport slave (
      input  E_Valid, E_MDUOp, E_RS, E_RT, D_UseMDU,
      output E_Start, E_Busy, E_MDUStall, E_HI, E_LO, E_MDUResult
   );
endinterface

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: fixed-latency sequencing, HI/LO ownership.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB accumulate ops.
module mdu_ctrl #(
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input logic        clk,
   input logic        reset,
   mdu_ctrl_if.slave  bus
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
`endif

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [63:0] pend;
   logic        pend_wr;

   logic [3:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        is_mul;
   logic        is_div;
   logic        start;
   logic [63:0] sprod;
   logic [63:0] uprod;
   logic [31:0] dvd;
   logic [31:0] dvs;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [63:0] pend_d;
   logic        wr_d;

   assign op = bus.E_MDUOp;
   assign rs = bus.E_RS;
   assign rt = bus.E_RT;

`ifdef MDU_MADD_EN
   assign is_mul = (op == OP_MULT) || (op == OP_MULTU) ||
                   (op == OP_MADD) || (op == OP_MADDU) ||
                   (op == OP_MSUB);
`else
   assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
   assign is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign start  = bus.E_Valid && (is_mul || is_div) &&
                   (state == IDLE);

   // Low 64 bits of a sign-extended product equal the signed product.
   assign sprod = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
   assign uprod = {32'd0, rs} * {32'd0, rt};

   // One unsigned divider; signed DIV runs on magnitudes then fixes signs.
   always_comb begin
      dvd = rs;
      dvs = rt;
      if (op == OP_DIV) begin
         dvd = rs[31] ? -rs : rs;
         dvs = rt[31] ? -rt : rt;
      end
      uq = '0;
      ur = '0;
      if (dvs != '0) begin
         uq = dvd / dvs;
         ur = dvd % dvs;
      end
   end

   always_comb begin
      pend_d = '0;
      wr_d   = 1'b1;
      unique case (1'b1)
         (op == OP_MULT):  pend_d = sprod;
         (op == OP_MULTU): pend_d = uprod;
         (op == OP_DIV): begin
            wr_d   = (rt != '0);
            pend_d = {rs[31] ? -ur : ur,
                      (rs[31] ^ rt[31]) ? -uq : uq};
         end
         (op == OP_DIVU): begin
            wr_d   = (rt != '0);
            pend_d = {ur, uq};
         end
`ifdef MDU_MADD_EN
         (op == OP_MADD):  pend_d = {hi, lo} + sprod;
         (op == OP_MADDU): pend_d = {hi, lo} + uprod;
         (op == OP_MSUB):  pend_d = {hi, lo} - sprod;
`endif
         default: wr_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend    <= '0;
         pend_wr <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  pend    <= pend_d;
                  pend_wr <= wr_d;
                  cnt     <= is_div ? 4'(DIV_LAT) : 4'(MUL_LAT);
                  state   <= BUSY;
               end else if (bus.E_Valid && op == OP_MTHI) begin
                  hi <= rs;
               end else if (bus.E_Valid && op == OP_MTLO) begin
                  lo <= rs;
               end
            end
            BUSY: begin
               if (cnt <= 4'd1) begin
                  if (pend_wr) {hi, lo} <= pend;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.E_Start     = start;
   assign bus.E_Busy      = (state == BUSY);
   assign bus.E_MDUStall  = bus.D_UseMDU && (start || state == BUSY);
   assign bus.E_HI        = hi;
   assign bus.E_LO        = lo;
   assign bus.E_MDUResult = (op == OP_MFHI) ? hi :
                            (op == OP_MFLO) ? lo : 32'd0;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Execute-stage multiply/divide controller for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E stage and sequences a fixed-latency multi-cycle operation.
- Owns the HI/LO registers and raises a stall toward D stage while an MDU-using instruction must wait.
- Its read result joins the E-stage result mux next to the D-stage set-word result path.

Parameters:
- MUL_LAT, 5, busy cycles for mult/multu (legal 1..15)
- DIV_LAT, 10, busy cycles for div/divu (legal 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- E_Valid  input  1  E-stage slot holds a real instruction (0 = bubble)
- E_MDUOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB (9-11 only with the optional feature)
- E_RS  input  32  forwarded rs operand
- E_RT  input  32  forwarded rt operand
- D_UseMDU  input  1  D-stage instruction is any MDU op (1..8, plus 9..11 if enabled)
- E_Start  output  1  combinational: E_Valid and op in {1,2,3,4} (and 9..11 if enabled) and state IDLE
- E_Busy  output  1  registered: state == BUSY
- E_MDUStall  output  1  combinational: D_UseMDU & (E_Start | E_Busy)
- E_HI  output  32  architectural HI
- E_LO  output  32  architectural LO
- E_MDUResult  output  32  MFHI -> E_HI; MFLO -> E_LO; otherwise 0

Behaviour:
- Reset (async, any time, including mid-operation): state IDLE, cnt 0, HI 0, LO 0, pending result 0. An in-flight result is discarded. Outputs settle to 0 immediately.
- States and transitions:
  - IDLE -> BUSY on the clock edge where E_Start = 1.
    - Latch the computed 64-bit pending {hi,lo}.
    - Set cnt = MUL_LAT (ops 1,2,9..11) or DIV_LAT (ops 3,4).
  - BUSY, cnt > 1: cnt decrements on each edge.
  - BUSY, cnt == 1: on that edge, write pending to HI/LO and go to IDLE.
  - Net effect: E_Busy is high for exactly LAT cycles. A start issued at edge t makes the new HI/LO visible from edge t+LAT onward.
- Arithmetic (computed from operands at the start edge):
  - MULT: signed 32x32 -> 64; HI = upper, LO = lower.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO 0x80000000, HI 0.
  - DIVU: unsigned.
  - Divisor == 0: still busy for DIV_LAT cycles; HI/LO are left unchanged at completion.
- MTHI/MTLO: write E_RS into HI/LO on the next edge when E_Valid, in IDLE. No busy.
- MFHI/MFLO: combinational read of the current HI/LO. No stall of their own.
- Start or MTHI/MTLO arriving while BUSY:
  - Cannot occur legally, because the stall holds it in D.
  - If it does occur, it is ignored: no state change, HI/LO untouched.
- E_Valid = 0 or op NONE: no effect.
- D_UseMDU while IDLE and no start in E: no stall.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Ops 9/10/11 are legal and use MUL_LAT.
  - MADD: {HI,LO} + signed product. MADDU: {HI,LO} + unsigned product. MSUB: {HI,LO} − signed product.
  - All are 64-bit wrap-around.
  - The accumulator base is the HI/LO value at the start edge.
- Undefined:
  - Ops 9..11 are treated as NONE: no start, no busy.
  - D_UseMDU is not expected to flag them.

Test Plan:
- MULT rs=0xFFFFFFFE (−2), rt=3 at edge 0:
  - E_Busy high for cycles 1..5, E_MDUStall high whenever D_UseMDU=1 in those cycles.
  - After edge 5: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV rs=−7 (0xFFFFFFF9), rt=2:
  - Busy 10 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A DIVU 7/2 follow-up gives LO=3, HI=1.
- MTHI 0x12345678, then MFHI on the next cycle:
  - E_MDUResult=0x12345678, no busy, no stall.
  - With D_UseMDU=1 and E holding MFLO, no stall.
- DIV by zero with HI=0xAA, LO=0xBB preset: busy 10 cycles, then HI=0xAA, LO=0xBB unchanged.
- Reset asserted at busy cycle 3 of a MULTU: E_Busy drops immediately; HI=LO=0; a new MULT on the next clock runs the full 5 cycles.
- (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, then MADDU 1*1: after 5 busy cycles HI=1, LO=0. Without the macro, the same op causes no busy and no change.
